sub_alu_serial: RTL and testbench

SUB_ALU_SERIAL -- requirements
Module: sub_alu_serial

---
 rtl/sub_alu_serial.sv | 122 ++++++++++++
 tb/tb_sub_alu_serial.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sub_alu_serial.sv
// Bit-serial unsigned subtractor: g = a - b mod 2^WIDTH, plus borrow and zero flags.
// done rises WIDTH cycles after an accepted start; start is ignored while busy.
module sub_alu_serial #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] g,
  output logic             borrow,
  output logic             zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] diff;
  logic [CW-1:0]    cnt;
  logic             br;

  logic             accept;
  logic             last_bit;
  logic             ai;
  logic             bi;
  logic             d;
  logic             br_nxt;
  logic [WIDTH-1:0] diff_nxt;

  assign ai       = sa[0];
  assign bi       = sb[0];
  assign d        = ai ^ bi ^ br;
  assign br_nxt   = (~ai & bi) | (~(ai ^ bi) & br);
  assign diff_nxt = {d, diff[WIDTH-1:1]};
  assign last_bit = (state == SHIFT) && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        // a start here chains straight into the next operation
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sa     <= '0;
      sb     <= '0;
      diff   <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      g      <= '0;
      borrow <= 1'b0;
      zero   <= 1'b0;
    end else if (accept) begin
      sa   <= a;
      sb   <= b;
      diff <= '0;
      cnt  <= '0;
      br   <= 1'b0;
    end else if (state == SHIFT) begin
      sa   <= sa >> 1;
      sb   <= sb >> 1;
      diff <= diff_nxt;
      cnt  <= cnt + CW'(1);
      br   <= br_nxt;
      // result registers only move on completion so they hold during SHIFT
      if (last_bit) begin
        g      <= diff_nxt;
        borrow <= br_nxt;
        zero   <= (diff_nxt == '0);
      end
    end
  end

endmodule

// File: tb/tb_sub_alu_serial.sv
// Self-checking bench for sub_alu_serial: directed literal cases plus randomized traffic
// checked every cycle against a countdown/arithmetic reference model.
module tb_sub_alu_serial;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         start = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] g;
  logic         borrow;
  logic         zero;

  int checks = 0;
  int failures = 0;

  sub_alu_serial #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .g      (g),
    .borrow (borrow),
    .zero   (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an accepted operation is in flight for W edges, then its
  // arithmetic result appears with a one-cycle done.
  int           m_left = 0;
  bit           m_done = 0;
  logic [W-1:0] m_g = '0;
  bit           m_br = 0;
  bit           m_z = 0;
  logic [W-1:0] p_g = '0;
  bit           p_br = 0;
  bit           p_z = 0;

  always @(negedge rst) begin
    m_left = 0;
    m_done = 0;
    m_g    = '0;
    m_br   = 0;
    m_z    = 0;
  end

  always @(posedge clk) begin
    if (rst) begin
      if (m_left > 0) begin
        m_left--;
        m_done = 0;
        if (m_left == 0) begin
          m_g    = p_g;
          m_br   = p_br;
          m_z    = p_z;
          m_done = 1;
        end
      end else begin
        m_done = 0;
        if (start) begin
          p_g    = a - b;
          p_br   = (a < b);
          p_z    = (p_g == '0);
          m_left = W;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("busy",   int'(busy),   int'(m_left > 0));
    chk("done",   int'(done),   int'(m_done));
    chk("g",      int'(g),      int'(m_g));
    chk("borrow", int'(borrow), int'(m_br));
    chk("zero",   int'(zero),   int'(m_z));
  end

  // Start one operation from IDLE/DONE and check latency and results as literals.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input int eg, input int ebr, input int ez, input string nm);
    int n;
    int busy_cnt;
    a     = ta;
    b     = tb_;
    start = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    n        = 0;
    busy_cnt = 0;
    while (!done && n < 10) begin
      if (busy) busy_cnt++;
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, "_latency"}, n, W);
    chk({nm, "_busy_cycles"}, busy_cnt, W);
    chk({nm, "_g"}, int'(g), eg);
    chk({nm, "_borrow"}, int'(borrow), ebr);
    chk({nm, "_zero"}, int'(zero), ez);
    @(posedge clk);
    #1;
    chk({nm, "_done_single"}, int'(done), 0);
  endtask

  initial begin
    int n;
    #2;
    chk("reset_g", int'(g), 0);
    chk("reset_flags", int'({busy, done, borrow, zero}), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;

    run_op(3'd3, 3'd2, 1, 0, 0, "sub_3_2");
    run_op(3'd2, 3'd3, 7, 1, 0, "sub_2_3");
    run_op(3'd0, 3'd7, 1, 1, 0, "sub_0_7");
    run_op(3'd5, 3'd5, 0, 0, 1, "sub_5_5");
    run_op(3'd7, 3'd0, 7, 0, 0, "sub_7_0");

    // start and operand changes during SHIFT must not disturb the operation
    a = 3'd6; b = 3'd1; start = 1'b1;
    @(posedge clk); #1;
    a = 3'd0; b = 3'd0;
    @(posedge clk); #1;
    a = 3'd3; b = 3'd7;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("hold_done", int'(done), 1);
    chk("hold_g", int'(g), 5);
    @(posedge clk); #1;
    chk("hold_no_second_done", int'(done), 0);
    @(posedge clk); #1;
    chk("hold_idle", int'({busy, done}), 0);

    // back-to-back: start held high through DONE picks up new operands
    a = 3'd5; b = 3'd2; start = 1'b1;
    @(posedge clk); #1;
    a = 3'd4; b = 3'd6;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("b2b_first_done", int'(done), 1);
    chk("b2b_first_g", int'(g), 3);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_reenter_busy", int'(busy), 1);
    chk("b2b_done_dropped", int'(done), 0);
    chk("b2b_g_held", int'(g), 3);
    n = 0;
    while (!done && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b2b_latency", n, W);
    chk("b2b_second_g", int'(g), 6);
    chk("b2b_second_borrow", int'(borrow), 1);
    @(posedge clk); #1;

    // asynchronous reset after the second SHIFT edge aborts the operation
    a = 3'd3; b = 3'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("arst_g", int'(g), 0);
    chk("arst_flags", int'({busy, done, borrow, zero}), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (done) n++;
    end
    chk("arst_no_done", n, 0);
    run_op(3'd1, 3'd1, 0, 0, 1, "after_reset_1_1");

    // randomized traffic, including occasional resets
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      a     = W'($urandom);
      b     = W'($urandom);
      start = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 59) == 0) begin
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
      end
    end
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
